// File: rtl/volume_integrator_multi.sv
// Multi-channel sliding-window integrator: per-channel running sum and average of the last 2^WINDOW_LOG2 samples.
// Define VOLUME_INTEGRATOR_PEAK_EN to add per-channel peak tracking of the average (peak_avg_o, peak_clear_i).
module volume_integrator_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WINDOW_LOG2 = 4,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned SUM_W      = DATA_W + WINDOW_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CH_W-1:0]   in_chan_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              clear_i,
  output logic              out_valid_o,
  output logic [CH_W-1:0]   out_chan_o,
  output logic [SUM_W-1:0]  out_sum_o,
  output logic [DATA_W-1:0] out_avg_o,
  output logic              out_full_o,
  output logic              drop_err_o
`ifdef VOLUME_INTEGRATOR_PEAK_EN
  ,
  input  logic              peak_clear_i,
  output logic [DATA_W-1:0] peak_avg_o
`endif
);

  localparam int unsigned WINDOW = 1 << WINDOW_LOG2;
  localparam int unsigned PTR_W  = WINDOW_LOG2;
  localparam int unsigned FILL_W = WINDOW_LOG2 + 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  k_q, k_d;
  logic              ready_q, ready_d;
  logic [PTR_W-1:0]  ptr_q  [CHANNELS];
  logic [PTR_W-1:0]  ptr_d  [CHANNELS];
  logic [FILL_W-1:0] fill_q [CHANNELS];
  logic [FILL_W-1:0] fill_d [CHANNELS];
  logic [SUM_W-1:0]  sum_q  [CHANNELS];
  logic [SUM_W-1:0]  sum_d  [CHANNELS];
  logic [DATA_W-1:0] win_q  [CHANNELS][WINDOW];

  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_chan_q, out_chan_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_avg_q, out_avg_d;
  logic              out_full_q, out_full_d;
  logic              drop_err_q, drop_err_d;

`ifdef VOLUME_INTEGRATOR_PEAK_EN
  logic [DATA_W-1:0] peak_q [CHANNELS];
  logic [DATA_W-1:0] peak_d [CHANNELS];
  logic [DATA_W-1:0] peak_avg_q, peak_avg_d;
`endif

  logic              chan_ok;
  logic [CH_W-1:0]   chan_idx;
  logic              accept;
  logic              win_we;
  logic [DATA_W-1:0] old_smp;
  logic [SUM_W-1:0]  new_sum;
  logic [FILL_W-1:0] new_fill;
  logic [DATA_W-1:0] new_avg;

  // Out-of-range channels are steered to bank 0 for the read path and never written.
  assign chan_ok  = ({1'b0, in_chan_i} < (CH_W + 1)'(CHANNELS));
  assign chan_idx = chan_ok ? in_chan_i : '0;
  assign accept   = in_valid_i & ready_q & ~clear_i;
  assign old_smp  = win_q[chan_idx][ptr_q[chan_idx]];
  // The evicted sample is always part of sum_q, so modular arithmetic yields the exact result.
  assign new_sum  = sum_q[chan_idx] + SUM_W'(in_data_i) - SUM_W'(old_smp);
  assign new_fill = (fill_q[chan_idx] == FILL_W'(WINDOW)) ? fill_q[chan_idx]
                                                          : fill_q[chan_idx] + 1'b1;
  assign new_avg  = DATA_W'(new_sum >> WINDOW_LOG2);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ready_d     = ready_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    out_chan_d  = out_chan_q;
    out_sum_d   = out_sum_q;
    out_avg_d   = out_avg_q;
    out_full_d  = out_full_q;
    drop_err_d  = drop_err_q;
    win_we      = 1'b0;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
    peak_d      = peak_q;
    peak_avg_d  = peak_avg_q;
`endif

    case (state_q)
      ST_CLEAR: begin
        if (k_q == PTR_W'(WINDOW - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (chan_ok) begin
            win_we             = 1'b1;
            ptr_d[chan_idx]    = ptr_q[chan_idx] + 1'b1;
            fill_d[chan_idx]   = new_fill;
            sum_d[chan_idx]    = new_sum;
            out_valid_d        = 1'b1;
            out_chan_d         = chan_idx;
            out_sum_d          = new_sum;
            out_avg_d          = new_avg;
            out_full_d         = (new_fill == FILL_W'(WINDOW));
          end else begin
            drop_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ready_d = 1'b0;
      end
    endcase

    if (clear_i) begin
      state_d    = ST_CLEAR;
      k_d        = '0;
      ready_d    = 1'b0;
      drop_err_d = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_d[c]  = '0;
        fill_d[c] = '0;
        sum_d[c]  = '0;
      end
    end

`ifdef VOLUME_INTEGRATOR_PEAK_EN
    if (out_valid_d && (new_avg > peak_q[chan_idx])) begin
      peak_d[chan_idx] = new_avg;
    end
    if (clear_i || peak_clear_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        peak_d[c] = '0;
      end
    end
    peak_avg_d = peak_d[out_chan_d];
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      k_q         <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_sum_q   <= '0;
      out_avg_q   <= '0;
      out_full_q  <= 1'b0;
      drop_err_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
        sum_q[c]  <= '0;
      end
`ifdef VOLUME_INTEGRATOR_PEAK_EN
      peak_avg_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        peak_q[c] <= '0;
      end
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_sum_q   <= out_sum_d;
      out_avg_q   <= out_avg_d;
      out_full_q  <= out_full_d;
      drop_err_q  <= drop_err_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
      peak_avg_q  <= peak_avg_d;
      peak_q      <= peak_d;
`endif
    end
  end

  // Sample windows: zero sweep of row k while clearing, otherwise the accepted sample.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (state_q == ST_CLEAR) begin
        win_q[c][k_q] <= '0;
      end else if (win_we && (chan_idx == CH_W'(c))) begin
        win_q[c][ptr_q[c]] <= in_data_i;
      end
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_chan_o  = out_chan_q;
  assign out_sum_o   = out_sum_q;
  assign out_avg_o   = out_avg_q;
  assign out_full_o  = out_full_q;
  assign drop_err_o  = drop_err_q;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
  assign peak_avg_o  = peak_avg_q;
`endif

endmodule

// File: tb/tb_volume_integrator_multi.sv
// Self-checking bench for volume_integrator_multi: queue-based window model, per-cycle compare, directed and random stimulus.
module tb_volume_integrator_multi;

  localparam int unsigned CHANNELS    = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned WINDOW_LOG2 = 2;
  localparam int unsigned WINDOW      = 1 << WINDOW_LOG2;
  localparam int unsigned CH_W        = 2;
  localparam int unsigned SUM_W       = DATA_W + WINDOW_LOG2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH_W-1:0]   in_chan = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              clear = 1'b0;
  logic              out_valid;
  logic [CH_W-1:0]   out_chan;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_avg;
  logic              out_full;
  logic              drop_err;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
  logic              peak_clear = 1'b0;
  logic [DATA_W-1:0] peak_avg;
`endif

  // Second instance with 5 channels: a 3-bit in_chan can encode channel 5, which 2 bits cannot.
  logic              v5 = 1'b0;
  logic              rdy5;
  logic [2:0]        c5 = '0;
  logic [DATA_W-1:0] d5 = '0;
  logic              clr5 = 1'b0;
  logic              ov5;
  logic [2:0]        oc5;
  logic [SUM_W-1:0]  os5;
  logic [DATA_W-1:0] oa5;
  logic              of5;
  logic              de5;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
  logic [DATA_W-1:0] pk5;
`endif

  always #5 clk = ~clk;

  volume_integrator_multi #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .WINDOW_LOG2(WINDOW_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_chan_i(in_chan),
    .in_data_i(in_data), .clear_i(clear), .out_valid_o(out_valid), .out_chan_o(out_chan),
    .out_sum_o(out_sum), .out_avg_o(out_avg), .out_full_o(out_full), .drop_err_o(drop_err)
`ifdef VOLUME_INTEGRATOR_PEAK_EN
    , .peak_clear_i(peak_clear), .peak_avg_o(peak_avg)
`endif
  );

  volume_integrator_multi #(.CHANNELS(5), .DATA_W(DATA_W), .WINDOW_LOG2(WINDOW_LOG2)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v5), .in_ready_o(rdy5), .in_chan_i(c5),
    .in_data_i(d5), .clear_i(clr5), .out_valid_o(ov5), .out_chan_o(oc5),
    .out_sum_o(os5), .out_avg_o(oa5), .out_full_o(of5), .drop_err_o(de5)
`ifdef VOLUME_INTEGRATOR_PEAK_EN
    , .peak_clear_i(1'b0), .peak_avg_o(pk5)
`endif
  );

  typedef struct {
    int chan;
    int sum;
    int avg;
    int full;
    int peak;
  } res_t;

  int   n_checks = 0;
  int   n_err    = 0;
  res_t obs_q[$];
  bit   mon_en = 1'b0;

  // Reference model: the last WINDOW accepted samples of each channel, plus held result fields.
  int hist [CHANNELS][$];
  int e_peak [CHANNELS];
  int h_chan, h_sum, h_avg, h_full, h_peak;
  bit exp_valid, e_drop;
  int rdy_cnt;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hist[c].delete();
        e_peak[c] = 0;
      end
      h_chan = 0; h_sum = 0; h_avg = 0; h_full = 0; h_peak = 0;
      exp_valid = 1'b0; e_drop = 1'b0; rdy_cnt = WINDOW;
    end else if (mon_en) begin
      check("in_ready", int'(in_ready), int'(rdy_cnt == 0));
      check("out_valid", int'(out_valid), int'(exp_valid));
      check("out_chan", int'(out_chan), h_chan);
      check("out_sum", int'(out_sum), h_sum);
      check("out_avg", int'(out_avg), h_avg);
      check("out_full", int'(out_full), h_full);
      check("drop_err", int'(drop_err), int'(e_drop));
`ifdef VOLUME_INTEGRATOR_PEAK_EN
      check("peak_avg", int'(peak_avg), h_peak);
`endif
      if (out_valid) begin
        res_t r;
        r.chan = int'(out_chan); r.sum = int'(out_sum); r.avg = int'(out_avg);
        r.full = int'(out_full); r.peak = 0;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
        r.peak = int'(peak_avg);
`endif
        obs_q.push_back(r);
      end
      // Advance the model with the inputs presented during this cycle.
      exp_valid = 1'b0;
      if (in_valid && (rdy_cnt == 0) && !clear) begin
        if (int'(in_chan) < CHANNELS) begin
          int c;
          int s;
          c = int'(in_chan);
          hist[c].push_back(int'(in_data));
          if (hist[c].size() > WINDOW) void'(hist[c].pop_front());
          s = 0;
          for (int j = 0; j < hist[c].size(); j++) s += hist[c][j];
          h_chan = c; h_sum = s; h_avg = s / WINDOW;
          h_full = int'(hist[c].size() == WINDOW);
          exp_valid = 1'b1;
          if (h_avg > e_peak[c]) e_peak[c] = h_avg;
        end else begin
          e_drop = 1'b1;
        end
      end
      if (clear) begin
        for (int c = 0; c < CHANNELS; c++) begin
          hist[c].delete();
          e_peak[c] = 0;
        end
        e_drop = 1'b0;
        rdy_cnt = WINDOW;
      end else if (rdy_cnt > 0) begin
        rdy_cnt--;
      end
`ifdef VOLUME_INTEGRATOR_PEAK_EN
      if (peak_clear) begin
        for (int c = 0; c < CHANNELS; c++) e_peak[c] = 0;
      end
`endif
      h_peak = e_peak[h_chan];
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input bit v, input int ch, input int d, input bit clr, input bit pc);
    @(posedge clk);
    #1;
    in_valid = v;
    in_chan  = CH_W'(ch);
    in_data  = DATA_W'(d);
    clear    = clr;
`ifdef VOLUME_INTEGRATOR_PEAK_EN
    peak_clear = pc;
`else
    if (pc) clear = clr;
`endif
  endtask

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("wait_ready_timeout", int'(got), 1);
  endtask

  task automatic count_not_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    int v38 [5];
    int s38 [5];
    int a38 [5];
    int f38 [5];
    v38 = '{10, 20, 30, 40, 50};
    s38 = '{10, 30, 60, 100, 140};
    a38 = '{2, 7, 15, 25, 35};
    f38 = '{0, 0, 0, 1, 1};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_chan", int'(out_chan), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_avg", int'(out_avg), 0);
    check("rst_out_full", int'(out_full), 0);
    check("rst_drop_err", int'(drop_err), 0);

    // Release: in_ready low for exactly WINDOW cycles.
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    count_not_ready(cnt);
    check("release_not_ready_cycles", cnt, 4);

    // Back-to-back ch0 ramp.
    obs_q.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 0, v38[i], 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("ramp_n_results", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("ramp_sum", obs_q[i].sum, s38[i]);
        check("ramp_avg", obs_q[i].avg, a38[i]);
        check("ramp_full", obs_q[i].full, f38[i]);
      end
    end

    // Interleaved ch1 max-value and ch2 unit samples.
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1, 255, 1'b0, 1'b0);
      drive(1'b1, 2, 1, 1'b0, 1'b0);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("ilv_n_results", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      check("ilv_ch1_chan", obs_q[6].chan, 1);
      check("ilv_ch1_sum", obs_q[6].sum, 1020);
      check("ilv_ch1_avg", obs_q[6].avg, 255);
      check("ilv_ch2_chan", obs_q[7].chan, 2);
      check("ilv_ch2_sum", obs_q[7].sum, 4);
      check("ilv_ch2_avg", obs_q[7].avg, 1);
    end

    // Random traffic with occasional clears; the monitor does the checking.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, CHANNELS - 1)),
            ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)),
            $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    wait_ready();

    // Clear on an accept cycle: sample dropped, sweep restarts, channel empty afterwards.
    drive(1'b1, 0, 33, 1'b0, 1'b0);
    drive(1'b1, 0, 44, 1'b0, 1'b0);
    drive(1'b1, 0, 99, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    count_not_ready(cnt);
    check("clear_not_ready_cycles", cnt, 4);
    obs_q.delete();
    drive(1'b1, 0, 8, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("post_clear_n_results", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("post_clear_sum", obs_q[0].sum, 8);
      check("post_clear_full", obs_q[0].full, 0);
    end

`ifdef VOLUME_INTEGRATOR_PEAK_EN
    // Peak holds through a falling window and restarts after peak_clear.
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    obs_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 3, 100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 3, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("peak_n_results", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      for (int i = 3; i < 8; i++) check("peak_hold", obs_q[i].peak, 100);
      check("peak_last_avg", obs_q[7].avg, 0);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    obs_q.delete();
    drive(1'b1, 3, 40, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("peak_clr_n_results", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("peak_clr_avg", obs_q[0].avg, 10);
      check("peak_clr_peak", obs_q[0].peak, 10);
    end
`endif

    // Out-of-range channel on the 5-channel instance.
    @(posedge clk);
    #1;
    check("drop5_initial", int'(de5), 0);
    check("drop5_ready", int'(rdy5), 1);
    v5 = 1'b1; c5 = 3'd5; d5 = 8'd77;
    @(posedge clk);
    #1;
    v5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drop5_no_valid", int'(ov5), 0);
      check("drop5_sticky", int'(de5), 1);
    end
    @(posedge clk);
    #1;
    v5 = 1'b1; c5 = 3'd4; d5 = 8'd12;
    @(posedge clk);
    #1;
    v5 = 1'b0;
    @(negedge clk);
    check("drop5_ch4_valid", int'(ov5), 1);
    check("drop5_ch4_sum", int'(os5), 12);
    check("drop5_ch4_avg", int'(oa5), 3);
    check("drop5_kept", int'(de5), 1);
    @(posedge clk);
    #1;
    clr5 = 1'b1;
    @(posedge clk);
    #1;
    clr5 = 1'b0;
    @(negedge clk);
    check("drop5_cleared", int'(de5), 0);

    // Reset asserted with an accept pending: no result appears.
    @(posedge clk);
    #1;
    mon_en   = 1'b0;
    in_valid = 1'b1;
    in_chan  = 2'd1;
    in_data  = 8'd50;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_sum", int'(out_sum), 0);
    check("abort_out_chan", int'(out_chan), 0);
    check("abort_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
